// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   localparam logic [1:0] GRANT_I = 2'b01;
   localparam logic [1:0] GRANT_D = 2'b10;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I-cache miss port, the D-cache port, the arbiter and
// main memory. The master view is the arbiter itself, which owns the memory
// request lines and the per-requester responses. The slave view is the
// surrounding environment: the caches and the memory.
interface mem_arbiter_if #(
   parameter int A_WIDTH = 32
);
   logic [A_WIDTH-1:0] i_a;
   logic               i_strobe;
   logic [31:0]        i_dout;
   logic               i_ready;

   logic [A_WIDTH-1:0] d_a;
   logic               d_strobe;
   logic               d_rw;
   logic [31:0]        d_din;
   logic [31:0]        d_dout;
   logic               d_ready;

   logic [A_WIDTH-1:0] m_a;
   logic               m_strobe;
   logic               m_rw;
   logic [31:0]        m_din;
   logic [31:0]        m_dout;
   logic               m_ready;

   logic [1:0]         grant;
   logic               err;

   modport master (
      input  i_a, i_strobe, d_a, d_strobe, d_rw, d_din, m_dout, m_ready,
      output i_dout, i_ready, d_dout, d_ready, m_a, m_strobe, m_rw, m_din,
             grant, err
   );

   modport slave (
      output i_a, i_strobe, d_a, d_strobe, d_rw, d_din, m_dout, m_ready,
      input  i_dout, i_ready, d_dout, d_ready, m_a, m_strobe, m_rw, m_din,
             grant, err
   );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker. req[0]=I, req[1]=D; last is the
// one-hot owner of the previous grant. On a tie the side that did not own the
// last grant wins.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic [1:0] last,
   output logic [1:0] pick
);

   // Single requester wins outright; a tie goes to the side that did not go last.
   always_comb begin
      pick = 2'b00;
      case (req)
         2'b01:   pick = GRANT_I;
         2'b10:   pick = GRANT_D;
         2'b11:   pick = (last == GRANT_I) ? GRANT_D : GRANT_I;
         default: pick = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache miss port and the D-cache
// port. Grant is held until memory completes, the owner drops its strobe, or
// the transaction exceeds TIMEOUT cycles (which sets a sticky err).
//
// state  | meaning
// IDLE   | no owner; arbitrate among live strobes
// BUSY_I | I side owns memory, waiting for m_ready
// BUSY_D | D side owns memory, waiting for m_ready
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int A_WIDTH = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      last_q, last_d;
   logic            err_q, err_d;
   logic [1:0]      pick;
   logic            own_strobe;

   rr_pick2 u_pick (
      .req  ({bus.d_strobe, bus.i_strobe}),
      .last (last_q),
      .pick (pick)
   );

   // Read data is broadcast; only the ready pulse qualifies it.
   assign bus.i_dout = bus.m_dout;
   assign bus.d_dout = bus.m_dout;
   assign bus.err    = err_q;

   // State, busy-cycle counter, round-robin history and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= GRANT_I;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

   // Next-state, memory-port muxing and completion/abort/timeout handling.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_d       = last_q;
      err_d        = err_q;
      own_strobe   = 1'b0;
      bus.grant    = 2'b00;
      bus.m_strobe = 1'b0;
      bus.m_rw     = 1'b0;
      bus.m_a      = '0;
      bus.m_din    = '0;
      bus.i_ready  = 1'b0;
      bus.d_ready  = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pick == GRANT_I) begin
               state_d = BUSY_I;
               last_d  = GRANT_I;
            end else if (pick == GRANT_D) begin
               state_d = BUSY_D;
               last_d  = GRANT_D;
            end
         end

         BUSY_I, BUSY_D: begin
            bus.m_strobe = 1'b1;
            bus.m_din    = bus.d_din;
            cnt_d        = cnt_q + CW'(1);
            if (state_q == BUSY_I) begin
               bus.grant  = GRANT_I;
               bus.m_a    = bus.i_a;
               own_strobe = bus.i_strobe;
            end else begin
               bus.grant  = GRANT_D;
               bus.m_a    = bus.d_a;
               bus.m_rw   = bus.d_rw;
               own_strobe = bus.d_strobe;
            end

            // An owner that withdraws gets no ready even if memory answers now.
            if (!own_strobe) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (bus.m_ready) begin
               bus.i_ready = (state_q == BUSY_I);
               bus.d_ready = (state_q == BUSY_D);
               state_d     = IDLE;
               cnt_d       = '0;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule
